// File: rtl/mat_pkg.sv
// Shared definitions for the 2x2 matrix multiplier byte-stream front end.
package mat_pkg;

  localparam int ELEM_W = 8;
  localparam int N_ELEM = 4;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    SETTLE,
    SEND
  } state_t;

  // Bit offset of byte lane idx in a packed word; lane 0 (element 00) is the MSB byte.
  function automatic logic [4:0] lane_lsb(input logic [1:0] idx);
    return 5'((N_ELEM - 1 - int'(idx)) * ELEM_W);
  endfunction

endpackage

// File: rtl/mat_stream_loader_if.sv
// Byte input and byte output valid/ready streams of the matrix loader.
interface mat_stream_if;
  import mat_pkg::*;

  logic [ELEM_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ELEM_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  // The loader's view: consumes the input stream, produces the output stream.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  // The host's view: produces input bytes and sinks result bytes.
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

// File: rtl/mat_stream_loader.sv
// Collects 8 operand bytes into packed A/B words, waits for the external
// multiplier to settle, captures its product and streams it back as 4 bytes.
module mat_stream_loader
  import mat_pkg::*;
#(
  parameter int SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  mat_stream_if.slave       stream,
  output logic [WORD_W-1:0] mat_a,
  output logic [WORD_W-1:0] mat_b,
  input  logic [WORD_W-1:0] mat_res,
  output logic              busy,
  output logic [15:0]       frame_cnt
);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        idx;
  logic [3:0]        settle_cnt;
  logic [WORD_W-1:0] res;

  logic in_fire;
  logic out_fire;
  logic last_byte;
  logic settle_done;

  assign stream.in_ready  = (state == LOAD_A) || (state == LOAD_B);
  assign stream.out_valid = (state == SEND);
  assign stream.out_data  = (state == SEND) ? res[lane_lsb(idx) +: ELEM_W] : '0;
  assign busy             = !((state == LOAD_A) && (idx == 2'd0));

  assign in_fire     = stream.in_valid && stream.in_ready;
  assign out_fire    = stream.out_valid && stream.out_ready;
  assign last_byte   = (idx == 2'd3);
  assign settle_done = (settle_cnt == 4'(SETTLE_CYC - 1));

  // Next-state decode: advance after the 4th byte of each phase or when settling ends.
  always_comb begin
    // NOTE: default assigned first so every path drives state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      LOAD_A: if (in_fire && last_byte)  state_nxt = LOAD_B;
      LOAD_B: if (in_fire && last_byte)  state_nxt = SETTLE;
      SETTLE: if (settle_done)           state_nxt = SEND;
      SEND:   if (out_fire && last_byte) state_nxt = LOAD_A;
      default:                           state_nxt = LOAD_A;
    endcase
    if (flush) state_nxt = LOAD_A;
  end

  // State, counters and datapath registers; flush aborts the frame but keeps the data.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state      <= LOAD_A;
      idx        <= '0;
      settle_cnt <= '0;
      mat_a      <= '0;
      mat_b      <= '0;
      res        <= '0;
      frame_cnt  <= '0;
    end else begin
      state <= state_nxt;

      if (flush || (state_nxt != state)) begin
        idx        <= '0;
        settle_cnt <= '0;
      end else begin
        if (in_fire || out_fire) idx <= idx + 2'd1;
        if (state == SETTLE)     settle_cnt <= settle_cnt + 4'd1;
      end

      // A transfer coinciding with flush is dropped: no write, no count.
      if (!flush) begin
        if (in_fire && (state == LOAD_A)) mat_a[lane_lsb(idx) +: ELEM_W] <= stream.in_data;
        if (in_fire && (state == LOAD_B)) mat_b[lane_lsb(idx) +: ELEM_W] <= stream.in_data;
        if ((state == SETTLE) && settle_done) res <= mat_res;
        if (out_fire && last_byte) frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/mat_stream_loader.md
# mat_stream_loader

Byte-stream front end for the 2x2 matrix multiplier. Accepts eight operand bytes over a valid/ready input stream and assembles them into the packed 32-bit A and B operand words. It presents both words to the combinational multiplier, registers the packed result, and returns it as four bytes over a valid/ready output stream. It sits between the host-facing byte channel and the multiplier, one frame at a time.

## Interface

Parameters:
- SETTLE_CYC, 1, cycles the operands are held stable before the multiplier result is captured; legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst_n  in  1  synchronous reset, active-low
- flush  in  1  synchronous frame abort, active-high
- in_data  in  8  operand byte
- in_valid  in  1  in_data is valid
- in_ready  out  1  block accepts in_data this cycle
- out_data  out  8  result byte
- out_valid  out  1  out_data is valid
- out_ready  in  1  sink accepts out_data this cycle
- mat_a  out  32  packed A to the multiplier: {A00,A01,A10,A11}, A00 in [31:24]
- mat_b  out  32  packed B to the multiplier, same packing
- mat_res  in  32  packed product from the multiplier, same packing
- busy  out  1  high in every state except LOAD_A with byte index 0
- frame_cnt  out  16  completed frames; wraps at 0xFFFF -> 0

## Operation

- States and transitions:
  - LOAD_A: receives 4 bytes, then goes to LOAD_B.
  - LOAD_B: receives 4 bytes, then goes to SETTLE.
  - SETTLE: waits SETTLE_CYC cycles, then goes to SEND.
  - SEND: emits 4 bytes, then returns to LOAD_A.
- Transfers:
  - Input byte transfer = in_valid && in_ready.
  - Output byte transfer = out_valid && out_ready.
- Byte counter: 2-bit idx, shared by the LOAD and SEND states; reset to 0 on every state change.
- Byte placement:
  - LOAD_A writes byte idx into mat_a[31-8*idx -: 8].
  - LOAD_B writes mat_b the same way.
  - Bytes not yet written keep their previous-frame value.
- in_ready = 1 only in LOAD_A/LOAD_B. It is combinational from state only, with no dependence on in_valid.
- Capture: the result register loads mat_res on the final SETTLE edge.
- SEND:
  - out_valid = 1; out_data = result byte idx, MSB byte (Res00) first.
  - out_data is held stable while out_valid && !out_ready.
- frame_cnt increments on the edge of the 4th output transfer.
- Arithmetic: no arithmetic in this block. The multiplier's modulo-256 element sums pass through unchanged.
- Reset (rst_n low at an edge) forces:
  - state LOAD_A, idx 0, settle counter 0
  - mat_a = 0, mat_b = 0, result 0, frame_cnt 0
  - in_ready 1, out_valid 0, out_data 0, busy 0
- flush:
  - Returns to LOAD_A with idx 0 and settle counter 0.
  - mat_a, mat_b, result and frame_cnt are kept.
  - Takes priority over a simultaneous in/out transfer, which is dropped and not counted.
  - rst_n has priority over flush.
- Reset or flush mid-SEND: remaining bytes are discarded and out_valid is low the next cycle.

## Timing

- Input accept: one byte per cycle at full rate. 8 back-to-back bytes take 8 edges.
- Edge E0 accepts byte 8: SETTLE is entered and in_ready is low after E0.
- Capture happens on edge E0+SETTLE_CYC. out_valid is high after that edge, so result latency is SETTLE_CYC cycles.
- Output: one byte per cycle while out_ready = 1.
- After the 4th output transfer edge: in_ready = 1 and out_valid = 0 on the same cycle, so there is no dead cycle.
- mat_a and mat_b are stable from E0 through the capture edge.

## Structure

- Shared package mat_pkg holds:
  - ELEM_W = 8, N_ELEM = 4, WORD_W = 32
  - the state enum {LOAD_A, LOAD_B, SETTLE, SEND}
  - a byte-select function for the packed-word lane index
- The block has no sub-module. The multiplier is instantiated alongside it by the parent, wired mat_a/mat_b -> A/B and product -> mat_res.

## Test plan

- After reset:
  - Check in_ready=1, out_valid=0, busy=0, mat_a=mat_b=0, frame_cnt=0.
- Basic product, multiplier attached:
  - Stream 01 02 03 04 05 06 07 08.
  - Expect mat_a=0x01020304, mat_b=0x05060708.
  - Expect out bytes 13 16 2B 32 (0x13162B32), first out_valid SETTLE_CYC cycles after byte 8, then frame_cnt=1.
- Wrap-around:
  - Stream A=C8 01 00 00, B=02 00 00 00.
  - Expect out bytes 90 00 00 00.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in SEND.
  - Expect out_data=0x13 stable and in_ready=0.
  - Then release; expect the remaining bytes in order.
  - With in_valid toggling every other cycle, expect the same result.
- Flush with in_valid:
  - Assert flush together with in_valid on byte 6.
  - Expect state LOAD_A, idx 0, and that byte not written.
  - A fresh 8-byte frame then produces the correct result.
- Mid-SEND aborts:
  - Assert rst_n=0 after 2 output bytes; expect all reset values.
  - Repeat with flush; expect frame_cnt unchanged and out_valid=0 the next cycle.
